jk_count_driver: RTL and testbench
==================================

Name: jk_count_driver

Overview:
- Upstream excitation stage for a bank of WIDTH JK flip-flops sharing the same clk/rst.
- Reads the bank's Q back on q_fb and drives per-bit J/K so the bank behaves as a modulo-MODULUS up/down counter.
- Accepts parallel loads over a valid/ready handshake.
- Flags terminal count and any mismatch between predicted and actual bank state.

Parameters:
WIDTH, 4, number of JK flops in the driven bank.
MODULUS, 10, count range 0..MODULUS-1; legal range 2 to 2^WIDTH.

Ports:
clk  input  1  rising-edge clock, shared with the JK bank.
rst  input  1  asynchronous active-high reset, shared with the JK bank.
en  input  1  count enable.
up  input  1  direction: 1 = up, 0 = down; sampled every cycle.
load_valid  input  1  load request.
load_ready  output  1  load can be accepted this cycle.
load_data  input  WIDTH  value to load.
q_fb  input  WIDTH  Q outputs of the JK bank.
j  output  WIDTH  J inputs to the JK bank.
k  output  WIDTH  K inputs to the JK bank.
tc  output  1  one-cycle terminal-count pulse.
busy  output  1  high while in LOAD.
err  output  1  sticky error flag.

Behaviour:
- Excitation rule, combinational from the state register, q_fb, and the target value d:
  - IDLE: j = k = 0.
  - Otherwise, per bit i: if d[i] == q_fb[i] then j[i] = k[i] = 0 (hold); else j[i] = k[i] = 1 (toggle).
  - No other J/K combination is ever driven.
- States: IDLE, RUN, LOAD. Reset state is IDLE. Reset values: tc = 0, err = 0, exp_valid = 0, load_target = 0.
- IDLE -> RUN when en = 1. RUN -> IDLE when en = 0. Both transitions are evaluated at the clock edge.
- RUN target d:
  - up = 1: d = 0 if q_fb == MODULUS-1, else q_fb + 1.
  - up = 0: d = MODULUS-1 if q_fb == 0, else q_fb - 1.
  - If q_fb >= MODULUS (illegal): d = 0 and err is set.
- Load handshake:
  - load_ready = 1 in IDLE and RUN, 0 in LOAD.
  - A load is accepted at an edge where load_valid && load_ready.
  - On acceptance: load_target = load_data, or 0 if load_data >= MODULUS (err is set in that case).
  - Next state is LOAD.
- Same-cycle count and load: the acceptance cycle still applies its own RUN/IDLE excitation. The load takes effect in the following LOAD cycle.
- LOAD: lasts exactly one cycle, with d = load_target and busy = 1. It then exits to RUN if en = 1, else IDLE. en and up are ignored during LOAD.
- Prediction check:
  - At every edge in RUN or LOAD, register expected = d and set exp_valid = 1.
  - In IDLE, expected = q_fb (hold) with exp_valid = 1.
  - Whenever exp_valid = 1 and q_fb != expected, set err.
  - err is sticky; only rst clears it.
- tc: registered. It is 1 for exactly one cycle following an edge at which RUN applied a wrap (MODULUS-1 -> 0 going up, or 0 -> MODULUS-1 going down). A LOAD never raises tc.
- Reset mid-operation:
  - rst forces IDLE and j = k = 0 asynchronously, and clears tc, err, and exp_valid.
  - The bank also resets to 0 on the same rst.
  - The first post-reset cycle performs no prediction check (exp_valid = 0).
- Latency: the bank reflects a count step one edge after the excitation cycle, and reflects a load two edges after acceptance.

Test Plan:
- Reset, then en = 1, up = 1, MODULUS = 10 -> q_fb sequence 0, 1, ..., 9, 0; tc high for exactly the one cycle after 9 -> 0; err = 0.
- en = 1, up = 0 from 0 -> q_fb 9, 8, 7; tc pulses once after 0 -> 9; j = k = 4'b1001 during the 0 -> 9 cycle.
- load_valid with load_data = 6 while counting up at q_fb = 2 -> accept; q_fb = 3 at the next edge, busy = 1 for one cycle, q_fb = 6 after the LOAD edge, counting resumes 7, 8.
- load_data = 12 -> loads 0, err = 1 and stays 1 through further counting until rst.
- Bench forces q_fb = 5 while expected = 4 -> err = 1 the same cycle; force q_fb = 13 in RUN -> excitation targets 0 and err is set.
- Assert rst during a LOAD cycle -> j = k = 0, busy = 0, tc = 0, err = 0 immediately; after release, en = 0 holds q_fb at 0 with j = k = 0.

Source files
------------

// File: rtl/jk_count_driver.sv
// Excitation driver for a bank of JK flops: drives J/K so the bank counts modulo
// MODULUS up or down, accepts parallel loads, and watches the bank for divergence.
module jk_count_driver #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] load_target_q, load_target_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             exp_valid_q, exp_valid_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;

  logic             q_illegal;
  logic             ld_illegal;
  logic             load_accept;
  logic             mismatch;
  logic             wrap;
  logic             drive;
  logic [WIDTH-1:0] run_target;
  logic [WIDTH-1:0] target;

  assign q_illegal   = ({1'b0, q_fb} >= MOD_EXT);
  assign ld_illegal  = ({1'b0, load_data} >= MOD_EXT);
  assign load_ready  = (state_q != LOAD);
  assign load_accept = load_valid && load_ready;
  assign mismatch    = exp_valid_q && (q_fb != expected_q);

  always_comb begin
    run_target = '0;
    wrap       = 1'b0;
    if (q_illegal) begin
      run_target = '0;
    end else if (up) begin
      wrap       = (q_fb == MAX_VAL);
      run_target = wrap ? '0 : q_fb + 1'b1;
    end else begin
      wrap       = (q_fb == '0);
      run_target = wrap ? MAX_VAL : q_fb - 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    load_target_d = load_target_q;
    tc_d          = 1'b0;
    err_d         = err_q | mismatch;
    target        = q_fb;
    drive         = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        target = run_target;
        drive  = 1'b1;
        tc_d   = wrap;
        if (q_illegal) err_d = 1'b1;
        if (!en) state_d = IDLE;
      end
      LOAD: begin
        target  = load_target_q;
        drive   = 1'b1;
        state_d = en ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The accepting cycle keeps its own excitation; the load lands in LOAD.
    if (load_accept) begin
      state_d       = LOAD;
      load_target_d = ld_illegal ? '0 : load_data;
      if (ld_illegal) err_d = 1'b1;
    end

    expected_d  = target;
    exp_valid_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      load_target_q <= '0;
      expected_q    <= '0;
      exp_valid_q   <= 1'b0;
      tc_q          <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_target_q <= load_target_d;
      expected_q    <= expected_d;
      exp_valid_q   <= exp_valid_d;
      tc_q          <= tc_d;
      err_q         <= err_d;
    end
  end

  // Toggle exactly the bits that differ from the target; never set/reset-only.
  assign j    = (drive && !rst) ? (target ^ q_fb) : '0;
  assign k    = j;
  assign busy = (state_q == LOAD) && !rst;
  assign tc   = tc_q;
  assign err  = !rst && (err_q || mismatch);

endmodule

// File: tb/tb_jk_count_driver.sv
// Bench for jk_count_driver: a behavioural JK bank closes the loop, vector tables
// feed a scoreboard queue that is drained on the falling edge.
module tb_jk_count_driver;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             up = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] load_data = '0;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             tc;
  logic             busy;
  logic             err;

  logic             poke_en = 1'b0;
  logic [WIDTH-1:0] poke_val = '0;
  logic [WIDTH-1:0] bank_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       up;
    logic       lv;
    logic [3:0] ld;
    logic       poke;
    logic [3:0] pv;
    logic [3:0] eq;
    logic [3:0] ejk;
    logic       etc;
    logic       ebusy;
    logic       eerr;
    logic       erdy;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  string tag;

  jk_count_driver #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up         (up),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .q_fb       (q_fb),
    .j          (j),
    .k          (k),
    .tc         (tc),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank; a poke overwrites it to emulate a disturbed flop.
  function automatic logic [WIDTH-1:0] jkNext(input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] jj,
                                              input logic [WIDTH-1:0] kk);
    logic [WIDTH-1:0] n;
    for (int i = 0; i < WIDTH; i++) begin
      case ({jj[i], kk[i]})
        2'b00:   n[i] = q[i];
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        default: n[i] = ~q[i];
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)          bank_q <= '0;
    else if (poke_en) bank_q <= poke_val;
    else              bank_q <= jkNext(bank_q, j, k);
  end

  assign q_fb = bank_q;

  function automatic vec_t mk(input logic e, input logic u, input logic lv,
                              input logic [3:0] ld, input logic p, input logic [3:0] pv,
                              input logic [3:0] eq, input logic [3:0] ejk,
                              input logic etc, input logic ebusy, input logic eerr,
                              input logic erdy);
    vec_t v;
    v.en = e; v.up = u; v.lv = lv; v.ld = ld; v.poke = p; v.pv = pv;
    v.eq = eq; v.ejk = ejk; v.etc = etc; v.ebusy = ebusy; v.eerr = eerr; v.erdy = erdy;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    en         = v.en;
    up         = v.up;
    load_valid = v.lv;
    load_data  = v.ld;
    poke_en    = v.poke;
    poke_val   = v.pv;
    sb.push_back(v);
  endtask

  task automatic checkOutput(input string name);
    vec_t e;
    if (sb.size() == 0) begin
      cmp({name, " scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    cmp({name, " q_fb"},       32'(q_fb),       32'(e.eq));
    cmp({name, " j"},          32'(j),          32'(e.ejk));
    cmp({name, " k"},          32'(k),          32'(e.ejk));
    cmp({name, " tc"},         32'(tc),         32'(e.etc));
    cmp({name, " busy"},       32'(busy),       32'(e.ebusy));
    cmp({name, " err"},        32'(err),        32'(e.eerr));
    cmp({name, " load_ready"}, 32'(load_ready), 32'(e.erdy));
  endtask

  task automatic runVectors(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("%s[%0d]", name, i));
      @(posedge clk);
      #1;
    end
    vecs.delete();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    en = 1'b0; up = 1'b0; load_valid = 1'b0; load_data = '0;
    poke_en = 1'b0; poke_val = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    cmp("reset j", 32'(j), 32'd0);
    cmp("reset tc", 32'(tc), 32'd0);
    cmp("reset err", 32'(err), 32'd0);
    cmp("reset busy", 32'(busy), 32'd0);
    cmp("reset q_fb", 32'(q_fb), 32'd0);
    doReset();

    // Count up through the wrap.
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd0,4'h0,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd0,4'h1,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd1,4'h3,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd2,4'h1,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd3,4'h7,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd4,4'h1,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd5,4'h3,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd6,4'h1,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd7,4'hF,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd8,4'h1,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd9,4'h9,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd0,4'h1,1,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd1,4'h3,0,0,0,1));
    runVectors("up");

    // Count down from 0 through the wrap to 9.
    doReset();
    vecs.push_back(mk(1,0,0,4'd0,0,4'd0, 4'd0,4'h0,0,0,0,1));
    vecs.push_back(mk(1,0,0,4'd0,0,4'd0, 4'd0,4'h9,0,0,0,1));
    vecs.push_back(mk(1,0,0,4'd0,0,4'd0, 4'd9,4'h1,1,0,0,1));
    vecs.push_back(mk(1,0,0,4'd0,0,4'd0, 4'd8,4'hF,0,0,0,1));
    vecs.push_back(mk(1,0,0,4'd0,0,4'd0, 4'd7,4'h1,0,0,0,1));
    runVectors("down");

    // Load 6 while counting up at 2; up dropped during LOAD must be ignored.
    doReset();
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd0,4'h0,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd0,4'h1,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd1,4'h3,0,0,0,1));
    vecs.push_back(mk(1,1,1,4'd6,0,4'd0, 4'd2,4'h1,0,0,0,1));
    vecs.push_back(mk(1,0,0,4'd0,0,4'd0, 4'd3,4'h5,0,1,0,0));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd6,4'h1,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd7,4'hF,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0, 4'd8,4'h1,0,0,0,1));
    runVectors("load6");

    // Illegal load data loads 0 and latches err.
    doReset();
    vecs.push_back(mk(0,0,1,4'd12,0,4'd0, 4'd0,4'h0,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0, 0,4'd0, 4'd0,4'h0,0,1,1,0));
    vecs.push_back(mk(1,1,0,4'd0, 0,4'd0, 4'd0,4'h1,0,0,1,1));
    vecs.push_back(mk(1,1,0,4'd0, 0,4'd0, 4'd1,4'h3,0,0,1,1));
    vecs.push_back(mk(1,1,0,4'd0, 0,4'd0, 4'd2,4'h1,0,0,1,1));
    runVectors("load12");

    // Disturb the bank: 5 instead of 4, then an illegal 13.
    doReset();
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0,  4'd0, 4'h0,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0,  4'd0, 4'h1,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0,  4'd1, 4'h3,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0,  4'd2, 4'h1,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,1,4'd5,  4'd3, 4'h7,0,0,0,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0,  4'd5, 4'h3,0,0,1,1));
    vecs.push_back(mk(1,1,0,4'd0,1,4'd13, 4'd6, 4'h1,0,0,1,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0,  4'd13,4'hD,0,0,1,1));
    vecs.push_back(mk(1,1,0,4'd0,0,4'd0,  4'd0, 4'h1,0,0,1,1));
    runVectors("disturb");

    // Reset asserted in the middle of a LOAD cycle.
    doReset();
    vecs.push_back(mk(1,1,1,4'd7,0,4'd0, 4'd0,4'h0,0,0,0,1));
    runVectors("rstload");
    applyStimulus(mk(1,1,0,4'd0,0,4'd0, 4'd0,4'h7,0,1,0,0));
    @(negedge clk);
    checkOutput("rstload[1]");
    #1;
    rst = 1'b1;
    #1;
    cmp("rst_async j", 32'(j), 32'd0);
    cmp("rst_async k", 32'(k), 32'd0);
    cmp("rst_async busy", 32'(busy), 32'd0);
    cmp("rst_async tc", 32'(tc), 32'd0);
    cmp("rst_async err", 32'(err), 32'd0);
    cmp("rst_async load_ready", 32'(load_ready), 32'd1);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vecs.push_back(mk(0,1,0,4'd0,0,4'd0, 4'd0,4'h0,0,0,0,1));
    vecs.push_back(mk(0,1,0,4'd0,0,4'd0, 4'd0,4'h0,0,0,0,1));
    vecs.push_back(mk(0,1,0,4'd0,0,4'd0, 4'd0,4'h0,0,0,0,1));
    runVectors("postrst");

    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
